// File: rtl/rkold_prev_writer.sv
// Packs a scalar residual stream into no_of_units-wide words and writes them to the rKold_prev memory.
// Optional status counter words_written is enabled by defining RKOLD_WRITER_STATUS_EN.
module rkold_prev_writer #(
    parameter int element_width = 64,
    parameter int no_of_units   = 8,
    parameter int address_width = 20,
    parameter int base_address  = 0,
    parameter int max_words     = 1001
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [address_width-1:0]               vector_length,
    input  logic [element_width-1:0]               in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [element_width*no_of_units-1:0]   mem_input_data,
    output logic [address_width-1:0]               mem_address,
    output logic                                   mem_write_enable,
    output logic                                   busy,
    output logic                                   done,
`ifdef RKOLD_WRITER_STATUS_EN
    output logic [address_width-1:0]               words_written,
`endif
    output logic                                   error
);

    localparam int WORD_W = element_width * no_of_units;
    localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam int unsigned MAX_ELEMS = max_words * no_of_units;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(no_of_units - 1);
    localparam logic [address_width-1:0] BASE = address_width'(base_address);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]               state;
    logic [address_width-1:0] len_q;
    logic [address_width-1:0] elem_cnt;
    logic [address_width-1:0] word_idx;
    logic [LANE_W-1:0]        lane;
    logic [WORD_W-1:0]        asm_q;
    logic [WORD_W-1:0]        asm_next;
    logic                     accept;
    logic                     last_elem;

    assign accept    = in_valid & in_ready;
    assign last_elem = (elem_cnt == len_q - 1'b1);

    // The incoming element is merged into its lane so a full word can be written on the accepting edge.
    always_comb begin
        asm_next = asm_q;
        asm_next[lane*element_width +: element_width] = in_data;
    end

    // NOTE: sequential state uses non-blocking assignments only; the assembly register is a
    // flop bank (not a RAM), so it is cleared on reset like every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            len_q            <= '0;
            elem_cnt         <= '0;
            word_idx         <= '0;
            lane             <= '0;
            asm_q            <= '0;
            in_ready         <= 1'b0;
            mem_input_data   <= '0;
            mem_address      <= '0;
            mem_write_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
`ifdef RKOLD_WRITER_STATUS_EN
            words_written    <= '0;
`endif
        end else begin
            mem_write_enable <= 1'b0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error    <= 1'b0;
                        len_q    <= vector_length;
                        elem_cnt <= '0;
                        word_idx <= '0;
                        lane     <= '0;
                        asm_q    <= '0;
`ifdef RKOLD_WRITER_STATUS_EN
                        words_written <= '0;
`endif
                        if (vector_length == '0) begin
                            state <= DONE_ST;
                            busy  <= 1'b1;
                        end else if (32'(vector_length) > MAX_ELEMS) begin
                            error <= 1'b1;
                        end else begin
                            state    <= COLLECT;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        elem_cnt <= elem_cnt + 1'b1;
                        if (lane == LAST_LANE || last_elem) begin
                            // Clearing the assembly here lets the next element land in lane 0 without a stall.
                            mem_input_data   <= asm_next;
                            mem_address      <= BASE + word_idx;
                            mem_write_enable <= 1'b1;
                            word_idx         <= word_idx + 1'b1;
                            lane             <= '0;
                            asm_q            <= '0;
`ifdef RKOLD_WRITER_STATUS_EN
                            words_written    <= words_written + 1'b1;
`endif
                        end else begin
                            asm_q <= asm_next;
                            lane  <= lane + 1'b1;
                        end
                        if (last_elem) begin
                            in_ready <= 1'b0;
                            state    <= DONE_ST;
                        end
                    end
                end
                DONE_ST: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rkold_prev_writer.sv
// Self-checking bench for rkold_prev_writer: a word-level model predicts every memory write.
module tb_rkold_prev_writer;

    localparam int EW = 64;
    localparam int NU = 8;
    localparam int AW = 20;
    localparam int WW = EW * NU;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] vector_length;
    logic [EW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] mem_input_data;
    logic [AW-1:0] mem_address;
    logic          mem_write_enable;
    logic          busy;
    logic          done;
    logic          error;
`ifdef RKOLD_WRITER_STATUS_EN
    logic [AW-1:0] words_written;
`endif

    rkold_prev_writer #(
        .element_width(EW), .no_of_units(NU), .address_width(AW),
        .base_address(0), .max_words(1001)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .vector_length(vector_length),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_input_data(mem_input_data), .mem_address(mem_address),
        .mem_write_enable(mem_write_enable), .busy(busy), .done(done),
`ifdef RKOLD_WRITER_STATUS_EN
        .words_written(words_written),
`endif
        .error(error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] elem(input int v, input int k);
        return {32'(v), 32'(k)};
    endfunction

    typedef struct {
        logic [WW-1:0] data;
        logic [AW-1:0] addr;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           exp_e;
    int            cyc = 0;
    int            strobes = 0;
    int            dones = 0;
    int            last_strobe_cyc = 0;
    int            last_done_cyc = 0;
    logic [WW-1:0] last_data;
    logic [AW-1:0] last_addr;
    logic [WW-1:0] log_data [0:3];

    always @(posedge clk) cyc++;

    // Model of a vector: word w holds elements w*NU .. w*NU+NU-1, zero past the end.
    task automatic expect_vector(input int v, input int len);
        for (int w = 0; w < (len + NU - 1) / NU; w++) begin
            wr_t e;
            e.data = '0;
            for (int i = 0; i < NU; i++)
                if (w * NU + i < len) e.data[i*EW +: EW] = elem(v, w * NU + i);
            e.addr = AW'(w);
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every strobe against the model, and output hold between strobes.
    always @(negedge clk) begin
        if (reset) begin
            last_data = '0;
            last_addr = '0;
        end else begin
            if (mem_write_enable) begin
                strobes++;
                last_strobe_cyc = cyc;
                check("strobe_expected", WW'(exp_q.size() > 0), WW'(1));
                if (exp_q.size() > 0) begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", WW'(mem_address), WW'(exp_e.addr));
                    check("wr_data", mem_input_data, exp_e.data);
                end
                last_data = mem_input_data;
                last_addr = mem_address;
                if (mem_address < 4) log_data[mem_address[1:0]] = mem_input_data;
            end else begin
                check("hold_data", mem_input_data, last_data);
                check("hold_addr", WW'(mem_address), WW'(last_addr));
            end
            if (done) begin
                dones++;
                last_done_cyc = cyc;
            end
        end
    end

    task automatic pulse_start(input int len);
        @(negedge clk);
        vector_length = AW'(len);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input int v, input int count, input bit gap);
        int k = 0;
        int budget = count * 4 + 20;
        bit phase = 1'b1;
        while (k < count && budget > 0) begin
            in_valid = gap ? phase : 1'b1;
            in_data  = elem(v, k);
            phase    = ~phase;
            if (in_valid && in_ready) k++;
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0;
        check("feed_complete", WW'(k), WW'(count));
    endtask

    task automatic run_vector(input int v, input int len, input bit gap);
        int s0 = strobes;
        int d0 = dones;
        int budget = 10;
        expect_vector(v, len);
        pulse_start(len);
        feed(v, len, gap);
        while (dones == d0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("done_seen", WW'(dones - d0), WW'(1));
        check("strobe_count", WW'(strobes - s0), WW'((len + NU - 1) / NU));
        check("done_after_strobe", WW'(last_done_cyc), WW'(last_strobe_cyc + 1));
        check("model_drained", WW'(exp_q.size()), WW'(0));
        check("busy_after_done", WW'(busy), WW'(0));
        check("ready_after_done", WW'(in_ready), WW'(0));
    endtask

    initial begin
        int s0;
        int d0;
        reset = 1'b1; start = 1'b0; vector_length = '0; in_data = '0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", WW'(mem_write_enable), WW'(0));
        check("rst_busy", WW'(busy), WW'(0));
        check("rst_ready", WW'(in_ready), WW'(0));
        check("rst_data", mem_input_data, '0);
        reset = 1'b0;

        // Case 1: 16 elements back to back.
        run_vector(1, 16, 1'b0);
        check("c1_w0_lane7", WW'(log_data[0][7*EW +: EW]), WW'(64'h0000_0001_0000_0007));
        check("c1_w1_lane0", WW'(log_data[1][0 +: EW]), WW'(64'h0000_0001_0000_0008));
`ifdef RKOLD_WRITER_STATUS_EN
        check("words_written", WW'(words_written), WW'(2));
`endif

        // Case 2: partial final word.
        run_vector(2, 11, 1'b0);
        check("c2_w1_lane2", WW'(log_data[1][2*EW +: EW]), WW'(64'h0000_0002_0000_000a));
        check("c2_w1_upper_zero", WW'(log_data[1][WW-1:3*EW]), WW'(0));

        // Case 3: zero length.
        s0 = strobes; d0 = dones;
        pulse_start(0);
        check("c3_busy1", WW'(busy), WW'(1));
        check("c3_done0", WW'(done), WW'(0));
        @(negedge clk);
        check("c3_busy2", WW'(busy), WW'(0));
        check("c3_done2", WW'(done), WW'(1));
        @(negedge clk);
        check("c3_done3", WW'(done), WW'(0));
        check("c3_no_strobe", WW'(strobes - s0), WW'(0));

        // Case 4: oversize length, then recovery.
        s0 = strobes; d0 = dones;
        pulse_start(8009);
        check("c4_error", WW'(error), WW'(1));
        check("c4_busy", WW'(busy), WW'(0));
        repeat (3) @(negedge clk);
        check("c4_error_sticky", WW'(error), WW'(1));
        check("c4_no_strobe", WW'(strobes - s0), WW'(0));
        check("c4_no_done", WW'(dones - d0), WW'(0));
        run_vector(4, 8, 1'b0);
        check("c4_error_cleared", WW'(error), WW'(0));
        check("c4_w0_lane7", WW'(log_data[0][7*EW +: EW]), WW'(64'h0000_0004_0000_0007));

        // Case 5: in_valid toggling.
        run_vector(5, 16, 1'b1);
        check("c5_w1_lane7", WW'(log_data[1][7*EW +: EW]), WW'(64'h0000_0005_0000_000f));

        // Case 6: reset mid-vector discards the partial word.
        s0 = strobes;
        pulse_start(16);
        feed(6, 5, 1'b0);
        reset = 1'b1;
        #1;
        check("c6_ready", WW'(in_ready), WW'(0));
        check("c6_busy", WW'(busy), WW'(0));
        check("c6_we", WW'(mem_write_enable), WW'(0));
        check("c6_addr", WW'(mem_address), WW'(0));
        check("c6_data", mem_input_data, '0);
        check("c6_done_err", WW'({done, error}), WW'(0));
        @(negedge clk);
        reset = 1'b0;
        check("c6_no_strobe", WW'(strobes - s0), WW'(0));
        run_vector(7, 16, 1'b0);
        check("c6_w0_lane0", WW'(log_data[0][0 +: EW]), WW'(64'h0000_0007_0000_0000));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
